// File: rtl/gpio_arb_pkg.sv
// Shared types and constants for the GPIO pin-select arbiter family.
package gpio_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    GAP
  } state_t;

  localparam int unsigned GPIO_IDX_W    = 6;
  localparam int unsigned GPIO_NUM_PINS = 34;

  // Pin 0 is reserved as "no selection" on the decoder, so legal pins start at 1.
  function automatic logic idx_legal(input int unsigned idx, input int unsigned num_pins);
    return (idx != 0) && (idx <= num_pins);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or above the pointer, with wrap.
module rr_picker #(
  parameter int unsigned N     = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_winner,
  output logic             o_any_valid
);

  logic              w_found;
  logic [31:0]       w_sum;
  logic [PTR_W-1:0]  w_pos;

  always_comb begin
    o_winner = '0;
    w_found  = 1'b0;
    w_sum    = '0;
    w_pos    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_sum = 32'(i_ptr) + i;
      w_pos = PTR_W'(w_sum % N);
      if (!w_found && i_req[w_pos]) begin
        o_winner[w_pos] = 1'b1;
        w_found         = 1'b1;
      end
    end
  end

  assign o_any_valid = |i_req;

endmodule

// File: rtl/gpio_pin_arbiter.sv
// Round-robin owner of the GPIO pin-select path: per-grant dwell, forced idle gap,
// and rejection of pin indices the decoder cannot accept.
module gpio_pin_arbiter
  import gpio_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned IDX_W    = GPIO_IDX_W,
  parameter int unsigned NUM_PINS = GPIO_NUM_PINS,
  parameter int unsigned DWELL_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*IDX_W-1:0]   req_idx,
  input  logic [NUM_REQ*DWELL_W-1:0] req_dwell,
  output logic [NUM_REQ-1:0]         grant,
  output logic [IDX_W-1:0]           sel_idx,
  output logic                       busy,
  output logic [NUM_REQ-1:0]         done,
  output logic                       err,
  output logic [NUM_REQ-1:0]         err_id
);

  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             r_state;
  logic [ID_W-1:0]    r_ptr;
  logic [ID_W-1:0]    r_owner;
  logic [DWELL_W-1:0] r_cnt;

  logic [NUM_REQ-1:0] w_win;
  logic               w_any;
  logic [ID_W-1:0]    w_win_id;
  logic [ID_W-1:0]    w_ptr_next;
  logic [IDX_W-1:0]   w_win_idx;
  logic [DWELL_W-1:0] w_win_dwell;
  logic               w_win_legal;

  rr_picker #(
    .N     (NUM_REQ),
    .PTR_W (ID_W)
  ) u_picker (
    .i_req       (req),
    .i_ptr       (r_ptr),
    .o_winner    (w_win),
    .o_any_valid (w_any)
  );

  always_comb begin
    w_win_id = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_win[i]) w_win_id = ID_W'(i);
    end
  end

  assign w_win_idx   = req_idx[w_win_id*IDX_W +: IDX_W];
  assign w_win_dwell = req_dwell[w_win_id*DWELL_W +: DWELL_W];
  assign w_win_legal = idx_legal(32'(w_win_idx), NUM_PINS);
  assign w_ptr_next  = (w_win_id == ID_W'(NUM_REQ - 1)) ? '0 : w_win_id + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_cnt   <= '0;
      grant   <= '0;
      sel_idx <= '0;
      busy    <= 1'b0;
      done    <= '0;
      err     <= 1'b0;
      err_id  <= '0;
    end else begin
      done   <= '0;
      err    <= 1'b0;
      err_id <= '0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_ptr <= w_ptr_next;
            if (w_win_legal) begin
              r_state <= HOLD;
              r_owner <= w_win_id;
              grant   <= w_win;
              sel_idx <= w_win_idx;
              busy    <= 1'b1;
              // Loading dwell-1 gives exactly dwell HOLD cycles; dwell 0 behaves as 1.
              r_cnt   <= (w_win_dwell == '0) ? '0 : w_win_dwell - 1'b1;
            end else begin
              err    <= 1'b1;
              err_id <= w_win;
            end
          end
        end
        HOLD: begin
          if (!req[r_owner] || (r_cnt == '0)) begin
            r_state <= GAP;
            grant   <= '0;
            sel_idx <= '0;
            if (req[r_owner]) done <= grant;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        GAP: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          grant   <= '0;
          sel_idx <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_pin_arbiter.sv
// Directed bench for gpio_pin_arbiter; outputs are compared as one packed snapshot
// {grant, sel_idx, busy, done, err, err_id} one time unit after each rising edge.
module tb_gpio_pin_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [23:0] req_idx = '0;
  logic [31:0] req_dwell = '0;
  logic [3:0]  grant;
  logic [5:0]  sel_idx;
  logic        busy;
  logic [3:0]  done;
  logic        err;
  logic [3:0]  err_id;

  logic [19:0] obs;
  logic [19:0] exp_v;
  int n_checks = 0;
  int n_errors = 0;

  gpio_pin_arbiter #(
    .NUM_REQ  (4),
    .IDX_W    (6),
    .NUM_PINS (34),
    .DWELL_W  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_idx   (req_idx),
    .req_dwell (req_dwell),
    .grant     (grant),
    .sel_idx   (sel_idx),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_id    (err_id)
  );

  always #5 clk = ~clk;

  assign obs = {grant, sel_idx, busy, done, err, err_id};

  function automatic logic [19:0] mk(input logic [3:0] g, input int s, input logic b,
                                     input logic [3:0] d, input logic e, input logic [3:0] eid);
    return {g, 6'(s), b, d, e, eid};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input int idx, input int dw);
    req_idx[k*6 +: 6]   = 6'(idx);
    req_dwell[k*8 +: 8] = 8'(dw);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    tick();
    tick();
    exp_v = '0;
    n_checks++;
    if (obs !== exp_v) begin n_errors++; $display("FAIL reset_state: got %b want %b", obs, exp_v); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    set_ch(0, 5, 3);
    req = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      tick();
      exp_v = mk(4'b0001, 5, 1'b1, 4'b0000, 1'b0, 4'b0000);
      n_checks++;
      if (obs !== exp_v) begin n_errors++; $display("FAIL single_hold%0d: got %b want %b", c, obs, exp_v); end
    end
    tick();
    exp_v = mk(4'b0000, 0, 1'b1, 4'b0001, 1'b0, 4'b0000);
    n_checks++;
    if (obs !== exp_v) begin n_errors++; $display("FAIL single_gap_done: got %b want %b", obs, exp_v); end
    req = '0;
    tick();
    exp_v = '0;
    n_checks++;
    if (obs !== exp_v) begin n_errors++; $display("FAIL single_idle: got %b want %b", obs, exp_v); end
    tick();
    n_checks++;
    if (obs !== exp_v) begin n_errors++; $display("FAIL single_stay_idle: got %b want %b", obs, exp_v); end
  endtask

  task automatic test_round_robin();
    int idxs[4] = '{1, 2, 33, 34};
    int g;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) set_ch(k, idxs[k], 2);
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      g = n % 4;
      for (int c = 0; c < 2; c++) begin
        tick();
        exp_v = mk(4'(1 << g), idxs[g], 1'b1, 4'b0000, 1'b0, 4'b0000);
        n_checks++;
        if (obs !== exp_v) begin n_errors++; $display("FAIL rr_grant%0d_c%0d: got %b want %b", n, c, obs, exp_v); end
      end
      tick();
      exp_v = mk(4'b0000, 0, 1'b1, 4'(1 << g), 1'b0, 4'b0000);
      n_checks++;
      if (obs !== exp_v) begin n_errors++; $display("FAIL rr_gap%0d: got %b want %b", n, obs, exp_v); end
      if (n == 4) req = '0;
      tick();
      exp_v = '0;
      n_checks++;
      if (obs !== exp_v) begin n_errors++; $display("FAIL rr_idle%0d: got %b want %b", n, obs, exp_v); end
    end
  endtask

  task automatic test_illegal();
    set_ch(1, 0, 1);
    req = 4'b0010;
    tick();
    exp_v = mk(4'b0000, 0, 1'b0, 4'b0000, 1'b1, 4'b0010);
    n_checks++;
    if (obs !== exp_v) begin n_errors++; $display("FAIL illegal_idx0: got %b want %b", obs, exp_v); end
    req = '0;
    tick();
    exp_v = '0;
    n_checks++;
    if (obs !== exp_v) begin n_errors++; $display("FAIL illegal_pulse_end: got %b want %b", obs, exp_v); end
    set_ch(2, 35, 1);
    req = 4'b0100;
    tick();
    exp_v = mk(4'b0000, 0, 1'b0, 4'b0000, 1'b1, 4'b0100);
    n_checks++;
    if (obs !== exp_v) begin n_errors++; $display("FAIL illegal_idx35: got %b want %b", obs, exp_v); end
    req = '0;
    tick();
    exp_v = '0;
    n_checks++;
    if (obs !== exp_v) begin n_errors++; $display("FAIL illegal_pulse_end2: got %b want %b", obs, exp_v); end
    set_ch(3, 7, 1);
    req = 4'b1000;
    tick();
    exp_v = mk(4'b1000, 7, 1'b1, 4'b0000, 1'b0, 4'b0000);
    n_checks++;
    if (obs !== exp_v) begin n_errors++; $display("FAIL legal_after_err: got %b want %b", obs, exp_v); end
    tick();
    exp_v = mk(4'b0000, 0, 1'b1, 4'b1000, 1'b0, 4'b0000);
    n_checks++;
    if (obs !== exp_v) begin n_errors++; $display("FAIL legal_after_err_done: got %b want %b", obs, exp_v); end
    req = '0;
    tick();
    exp_v = '0;
    n_checks++;
    if (obs !== exp_v) begin n_errors++; $display("FAIL legal_after_err_idle: got %b want %b", obs, exp_v); end
  endtask

  task automatic test_early_release();
    set_ch(0, 12, 10);
    set_ch(1, 9, 1);
    req = 4'b0011;
    for (int c = 0; c < 2; c++) begin
      tick();
      exp_v = mk(4'b0001, 12, 1'b1, 4'b0000, 1'b0, 4'b0000);
      n_checks++;
      if (obs !== exp_v) begin n_errors++; $display("FAIL early_hold%0d: got %b want %b", c, obs, exp_v); end
    end
    req = 4'b0010;
    tick();
    exp_v = mk(4'b0000, 0, 1'b1, 4'b0000, 1'b0, 4'b0000);
    n_checks++;
    if (obs !== exp_v) begin n_errors++; $display("FAIL early_gap_nodone: got %b want %b", obs, exp_v); end
    tick();
    exp_v = '0;
    n_checks++;
    if (obs !== exp_v) begin n_errors++; $display("FAIL early_idle: got %b want %b", obs, exp_v); end
    tick();
    exp_v = mk(4'b0010, 9, 1'b1, 4'b0000, 1'b0, 4'b0000);
    n_checks++;
    if (obs !== exp_v) begin n_errors++; $display("FAIL early_next_grant: got %b want %b", obs, exp_v); end
    tick();
    exp_v = mk(4'b0000, 0, 1'b1, 4'b0010, 1'b0, 4'b0000);
    n_checks++;
    if (obs !== exp_v) begin n_errors++; $display("FAIL early_next_done: got %b want %b", obs, exp_v); end
    req = '0;
    tick();
  endtask

  task automatic test_reset_mid_hold();
    set_ch(2, 20, 5);
    req = 4'b0100;
    tick();
    exp_v = mk(4'b0100, 20, 1'b1, 4'b0000, 1'b0, 4'b0000);
    n_checks++;
    if (obs !== exp_v) begin n_errors++; $display("FAIL rst_hold_grant: got %b want %b", obs, exp_v); end
    rst = 1'b1;
    tick();
    exp_v = '0;
    n_checks++;
    if (obs !== exp_v) begin n_errors++; $display("FAIL rst_mid_hold: got %b want %b", obs, exp_v); end
    rst = 1'b0;
    set_ch(0, 1, 3);
    set_ch(1, 2, 3);
    set_ch(3, 33, 3);
    req = 4'b1111;
    tick();
    exp_v = mk(4'b0001, 1, 1'b1, 4'b0000, 1'b0, 4'b0000);
    n_checks++;
    if (obs !== exp_v) begin n_errors++; $display("FAIL rst_ptr_zero: got %b want %b", obs, exp_v); end
    req = '0;
    tick();
    exp_v = mk(4'b0000, 0, 1'b1, 4'b0000, 1'b0, 4'b0000);
    n_checks++;
    if (obs !== exp_v) begin n_errors++; $display("FAIL rst_release_gap: got %b want %b", obs, exp_v); end
    tick();
  endtask

  task automatic test_dwell_edges();
    set_ch(0, 34, 0);
    req = 4'b0001;
    tick();
    exp_v = mk(4'b0001, 34, 1'b1, 4'b0000, 1'b0, 4'b0000);
    n_checks++;
    if (obs !== exp_v) begin n_errors++; $display("FAIL dwell0_grant: got %b want %b", obs, exp_v); end
    tick();
    exp_v = mk(4'b0000, 0, 1'b1, 4'b0001, 1'b0, 4'b0000);
    n_checks++;
    if (obs !== exp_v) begin n_errors++; $display("FAIL dwell0_done: got %b want %b", obs, exp_v); end
    req = '0;
    tick();
    set_ch(0, 3, 4);
    req = 4'b0001;
    for (int c = 0; c < 4; c++) begin
      tick();
      exp_v = mk(4'b0001, 3, 1'b1, 4'b0000, 1'b0, 4'b0000);
      n_checks++;
      if (obs !== exp_v) begin n_errors++; $display("FAIL dwell4_hold%0d: got %b want %b", c, obs, exp_v); end
      set_ch(0, 40 + c, 1);
    end
    tick();
    exp_v = mk(4'b0000, 0, 1'b1, 4'b0001, 1'b0, 4'b0000);
    n_checks++;
    if (obs !== exp_v) begin n_errors++; $display("FAIL dwell4_done: got %b want %b", obs, exp_v); end
    req = '0;
    tick();
    exp_v = '0;
    n_checks++;
    if (obs !== exp_v) begin n_errors++; $display("FAIL dwell4_idle: got %b want %b", obs, exp_v); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_illegal();
    test_early_release();
    test_reset_mid_hold();
    test_dwell_edges();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
